muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the execute path. Accepts one operation at a time through a start/done handshake. Produces a 32-bit result that feeds one data input of the 4:1 writeback select mux. The control unit stalls the pipeline while `busy` is high.

---
 rtl/muldiv_unit.sv | 151 +++++++++++++++
 tb/tb_muldiv_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply, restoring divide.
// Define RV_MULDIV_DIV_EN to build the divider (ops 4-7); otherwise those ops return 0.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [2:0]  op_q;
  logic        neg_q;
  logic [31:0] m_q;
  logic [63:0] acc_q;
`ifdef RV_MULDIV_DIV_EN
  logic        rem_neg_q;
`endif

  logic        a_signed, b_signed, in_sa, in_sb;
  logic [31:0] mag_a, mag_b;
  logic        special;
  logic [31:0] special_res;
  logic [32:0] add_sum;
  logic [63:0] acc_step, prod_fix;
  logic [31:0] res_calc;
`ifdef RV_MULDIV_DIV_EN
  logic [32:0] sub_diff;
`endif

  // Request decode: operand signedness, magnitudes and divide special cases.
  // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    a_signed    = (op != 3'd3) && (op != 3'd5) && (op != 3'd7);
    b_signed    = (op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    in_sa       = a[31] & a_signed;
    in_sb       = b[31] & b_signed;
    mag_a       = in_sa ? -a : a;
    mag_b       = in_sb ? -b : b;
`ifdef RV_MULDIV_DIV_EN
    special     = op[2] && ((b == 32'd0) ||
                  (b_signed && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
    if (b == 32'd0) special_res = op[1] ? a : 32'hFFFF_FFFF;
    else            special_res = op[1] ? 32'd0 : 32'h8000_0000;
`else
    special     = op[2];
    special_res = 32'd0;
`endif
  end

  // One iteration; the multiplier / dividend sits in acc_q[31:0] and is shifted out.
  always_comb begin
    add_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, m_q} : 33'd0);
    acc_step = {add_sum, acc_q[31:1]};
`ifdef RV_MULDIV_DIV_EN
    sub_diff = acc_q[63:31] - {1'b0, m_q};
    if (op_q[2]) begin
      if (!sub_diff[32]) acc_step = {sub_diff[31:0], acc_q[30:0], 1'b1};
      else               acc_step = {acc_q[62:0], 1'b0};
    end
`endif
  end

  // Sign-corrected selection of the final value, taken from the last step's output.
  always_comb begin
    prod_fix = neg_q ? -acc_step : acc_step;
    case (op_q)
      3'd0:             res_calc = prod_fix[31:0];
      3'd1, 3'd2, 3'd3: res_calc = prod_fix[63:32];
`ifdef RV_MULDIV_DIV_EN
      3'd4, 3'd5:       res_calc = neg_q ? -acc_step[31:0] : acc_step[31:0];
      3'd6, 3'd7:       res_calc = rem_neg_q ? -acc_step[63:32] : acc_step[63:32];
`endif
      default:          res_calc = 32'd0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 5'd0;
      op_q      <= 3'd0;
      neg_q     <= 1'b0;
      m_q       <= 32'd0;
      acc_q     <= 64'd0;
`ifdef RV_MULDIV_DIV_EN
      rem_neg_q <= 1'b0;
`endif
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= 32'd0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE, FIN: begin
            if (start) begin
              op_q      <= op;
              neg_q     <= in_sa ^ in_sb;
`ifdef RV_MULDIV_DIV_EN
              rem_neg_q <= in_sa;
`endif
              m_q       <= mag_b;
              acc_q     <= {32'd0, mag_a};
              cnt       <= 5'd0;
              if (special) begin
                state  <= FIN;
                busy   <= 1'b0;
                done   <= 1'b1;
                result <= special_res;
              end else begin
                state <= CALC;
                busy  <= 1'b1;
              end
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          CALC: begin
            acc_q <= acc_step;
            cnt   <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              state  <= FIN;
              busy   <= 1'b0;
              done   <= 1'b1;
              result <= res_calc;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; divide expectations follow RV_MULDIV_DIV_EN.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op from a negedge in IDLE/FIN; optionally pulse a stray start during CALC.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp, input int exp_lat,
                        input int glitch_at);
    int   lat;
    int   nbusy;
    logic both;
    lat = 0; nbusy = 0; both = 1'b0;
    op = o; a = x; b = y; start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = (k == glitch_at);
      if (k == glitch_at) begin op = 3'd0; a = 32'd11; b = 32'd11; end
      if (busy) nbusy++;
      if (busy && done) both = 1'b1;
      if (done) begin lat = k; break; end
    end
    check({tag, "_result"}, result, exp);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_cycles"}, nbusy, (exp_lat == 1) ? 0 : 32);
    check({tag, "_busy_and_done"}, both, 1'b0);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 1'b0);
  endtask

  task automatic no_done_for(input string tag, input int n);
    int seen;
    seen = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check({tag, "_quiet"}, seen, 0);
  endtask

  initial begin
    int   lat;
    logic held;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_result", result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Multiply variants
    run_op("mul_7x6",      3'd0, 32'd7,          32'd6,          32'd42,         33, 0);
    run_op("mul_neg3x5",   3'd0, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1,  33, 0);
    run_op("mulh_neg3x5",  3'd1, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFFF,  33, 0);
    run_op("mulh_min",     3'd1, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  33, 0);
    run_op("mulhsu_ones",  3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  33, 0);
    run_op("mulhu_ones",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  33, 0);

    // Divide variants and special cases
`ifdef RV_MULDIV_DIV_EN
    run_op("div_m7_2",     3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33, 0);
    run_op("rem_m7_2",     3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33, 0);
    run_op("divu_100_7",   3'd5, 32'd100,        32'd7,          32'd14,         33, 0);
    run_op("remu_100_7",   3'd7, 32'd100,        32'd7,          32'd2,          33, 0);
    run_op("div_9_3",      3'd4, 32'd9,          32'd3,          32'd3,          33, 0);
    run_op("divu_5_0",     3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF,  1,  0);
    run_op("remu_5_0",     3'd7, 32'd5,          32'd0,          32'd5,          1,  0);
    run_op("div_m1_0",     3'd4, 32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF,  1,  0);
    run_op("div_ovf",      3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,  0);
    run_op("rem_ovf",      3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1,  0);
`else
    run_op("div_9_3_off",  3'd4, 32'd9,          32'd3,          32'd0,          1,  0);
    run_op("remu_100_7_off", 3'd7, 32'd100,      32'd7,          32'd0,          1,  0);
`endif

    // Stray start during CALC is ignored
    run_op("mul_glitch",   3'd0, 32'd3,          32'd5,          32'd15,         33, 5);

    // Back-to-back: start during FIN, next done 33 cycles later, result held meanwhile
    run_op("mul_prev",     3'd0, 32'd7,          32'd6,          32'd42,         33, 0);
    op = 3'd0; a = 32'd4; b = 32'd5; start = 1'b1;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        op = 3'd3; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
        lat = k;
        break;
      end
    end
    check("b2b_first_latency", lat, 33);
    check("b2b_first_result", result, 32'd20);
    lat = 0; held = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin lat = k; break; end
      if (result !== 32'd20) held = 1'b0;
    end
    check("b2b_second_latency", lat, 33);
    check("b2b_second_result", result, 32'hFFFF_FFFE);
    check("b2b_result_held", held, 1'b1);
    @(negedge clk);

    // Flush at cycle 10 of a MUL
    op = 3'd0; a = 32'd5; b = 32'd5; start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 10) flush = 1'b1;
    end
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", busy, 1'b0);
    check("flush_done", done, 1'b0);
    check("flush_result", result, 32'hFFFF_FFFE);
    no_done_for("flush", 40);
    run_op("mul_after_flush", 3'd0, 32'd3, 32'd3, 32'd9, 33, 0);

    // Flush and start together: request dropped
    op = 3'd0; a = 32'd2; b = 32'd2; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", busy, 1'b0);
    no_done_for("flush_start", 40);
    check("flush_start_result", result, 32'd9);

    // Asynchronous reset at cycle 15 of an iterating op
`ifdef RV_MULDIV_DIV_EN
    op = 3'd5; a = 32'd100; b = 32'd7;
`else
    op = 3'd0; a = 32'd100; b = 32'd7;
`endif
    start = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("pre_reset_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_reset_busy", busy, 1'b0);
    check("async_reset_done", done, 1'b0);
    check("async_reset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    no_done_for("post_reset", 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
